riscv_cache_fill_ctrl: RTL and testbench
========================================

# riscv_cache_fill_ctrl

Miss-handling and line-fill controller for the RISC-V set-associative caches. On a lookup miss it selects a victim way per set (round-robin), issues a single burst read on the BIU, assembles the returned beats into one cache line, and presents that line together with the fill-way one-hot to the cache tag/data memory block. It also sequences cache-wide invalidation (flush) and stalls the core pipeline while either operation is in progress.

## Interface
Parameters:
- XLEN, 32, data and beat width
- PLEN, XLEN, physical address width
- SIZE, 4, cache size in KBytes
- BLOCK_SIZE, XLEN, line size in bytes
- WAYS, 2, associativity (power of 2, ≥2)
- Derived (localparam): SETS, IDX_BITS, BLK_OFFS_BITS, BLK_BITS from the package functions; BEATS = BLK_BITS/XLEN (power of 2, ≥1)

Ports (clock and reset first; one clock, reset is synchronous and active-low):
- clk_i  in  1  clock
- rst_ni  in  1  synchronous reset, active low
- miss_i  in  1  lookup missed; request a fill (level, sampled in IDLE)
- miss_adr_i  in  PLEN  physical address of missing access
- flush_i  in  1  invalidate whole cache (sampled in IDLE)
- busy_o  out  1  fill/flush in progress; core stalls
- filling_o  out  1  fill in progress (REQ..WRITE)
- flushing_o  out  1  one-cycle invalidate strobe
- fill_way_select_o  out  WAYS  one-hot victim way
- line_o  out  BLK_BITS  assembled cache line
- line_we_o  out  1  one-cycle line write strobe (drives memory ack input)
- biu_stb_o  out  1  burst request
- biu_stb_ack_i  in  1  BIU accepted request
- biu_adr_o  out  PLEN  line-aligned burst address
- biu_len_o  out  8  burst length, BEATS-1
- biu_d_i  in  XLEN  read beat data
- biu_ack_i  in  1  read beat valid
- biu_err_i  in  1  bus error
- err_o  out  1  one-cycle error pulse

## Operation
- FSM states IDLE, REQ, RECV, WRITE, FLUSH.
- IDLE: flush_i → FLUSH (priority over miss_i). Else miss_i → REQ; latch biu_adr_o = miss_adr_i with low BLK_OFFS_BITS zeroed; latch fill_way_select_o = one-hot of victim pointer of set miss_adr_i[idx].
- REQ: biu_stb_o=1, address/len held stable; biu_stb_ack_i → RECV, beat counter=0.
- RECV: each biu_ack_i writes biu_d_i into line_o[cnt*XLEN +: XLEN], cnt++; ack on beat BEATS-1 → WRITE. biu_ack_i ignored outside RECV.
- WRITE: line_we_o=1 one cycle; victim pointer of the set increments modulo WAYS (wrap WAYS-1→0); → IDLE.
- FLUSH: flushing_o=1 one cycle; all victim pointers cleared; → IDLE.
- biu_err_i in REQ or RECV: → IDLE, err_o pulses, no line_we_o, victim pointer unchanged. err wins over simultaneous biu_ack_i/biu_stb_ack_i.
- busy_o = state≠IDLE; filling_o = state∈{REQ,RECV,WRITE}.
- BEATS=1: first ack in RECV goes straight to WRITE.

## Timing
- Reset values: all outputs 0, state IDLE, counter 0, all victim pointers 0, line_o 0.
- Reset asserted mid-fill or mid-flush: next edge returns to IDLE, no line_we_o/flushing_o issued.
- miss_i sampled at edge N → biu_stb_o high from N+1.
- biu_stb_ack_i at edge M → beats accepted from M+1.
- Last beat at edge K → line_we_o high in cycle K+1 only; busy_o low from K+2; a new miss_i may be accepted at edge K+2.
- line_o and fill_way_select_o stable from WRITE until the next fill starts.
- flush_i at edge N → flushing_o high in cycle N+1 only; busy_o low from N+2.

## Structure
- SETS/IDX/offset/block-bit functions come from riscv_cache_pkg; add the FSM state enum there as a shared typedef.
- Sub-module riscv_cache_victim_sel: per-set round-robin pointer array (SETS × log2(WAYS) flops), read port by index, increment and clear-all inputs, one-hot output.

## Test plan
- Default params (BEATS=8), miss at 0x0000_1234 → biu_adr_o=0x0000_1220, biu_len_o=7; beats 0x0..0x7 → line_o word i = i, line_we_o one cycle, fill_way_select_o=01.
- Two misses to the same set → fill_way_select_o 01 then 10; third miss → 01 (wrap-around).
- flush_i and miss_i in the same IDLE cycle → flushing_o pulse, no biu_stb_o; subsequent miss to a previously filled set → way 01.
- biu_err_i together with beat 3 → err_o pulse, no line_we_o, next miss to that set reuses the same way.
- rst_ni low during RECV beat 5 → all outputs 0 next cycle, victim pointers 0, new miss restarts the burst cleanly.
- biu_stb_ack_i withheld for 10 cycles → biu_stb_o and biu_adr_o held stable, busy_o high throughout.

Source files
------------

// File: rtl/riscv_cache_pkg.sv
// Shared cache geometry helpers and the fill-controller state type.
package riscv_cache_pkg;

    // Number of sets for a cache of 'size' KBytes split into 'ways' ways.
    function automatic int get_sets(input int size, input int block_size, input int ways);
        return (size * 1024) / block_size / ways;
    endfunction

    // Bits needed to index one set.
    function automatic int get_idx_bits(input int size, input int block_size, input int ways);
        return $clog2(get_sets(size, block_size, ways));
    endfunction

    // Byte-offset bits inside one line.
    function automatic int get_blk_offs_bits(input int block_size);
        return $clog2(block_size);
    endfunction

    // Line width in bits.
    function automatic int get_blk_bits(input int block_size);
        return block_size * 8;
    endfunction

    // Miss/fill controller states; shared so checkers can decode state.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_RECV  = 3'd2,
        ST_WRITE = 3'd3,
        ST_FLUSH = 3'd4
    } fill_state_e;

endpackage

// File: rtl/riscv_cache_victim_sel.sv
// Per-set round-robin victim pointer array with one-hot way output.
module riscv_cache_victim_sel #(
    parameter int SETS  = 64,
    parameter int WAYS  = 2,
    parameter int IDX_W = (SETS > 1) ? $clog2(SETS) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [WAYS-1:0]  way_onehot,
    input  logic             inc,
    input  logic [IDX_W-1:0] inc_idx,
    input  logic             clear
);
    localparam int PTR_W = $clog2(WAYS);
    localparam logic [PTR_W-1:0] LAST_WAY = PTR_W'(WAYS - 1);

    logic [PTR_W-1:0] ptr [SETS];

    // Pointer update: clear-all wins over a single-set increment.
    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            for (int s = 0; s < SETS; s++) begin
                ptr[s] <= '0;
            end
        end else if (inc) begin
            ptr[inc_idx] <= (ptr[inc_idx] == LAST_WAY) ? '0 : ptr[inc_idx] + 1'b1;
        end
    end

    // Decode the addressed set's pointer to a one-hot way.
    always_comb begin
        way_onehot = '0;
        way_onehot[ptr[rd_idx]] = 1'b1;
    end

endmodule

// File: rtl/riscv_cache_fill_ctrl.sv
// Cache miss handler: victim pick, single burst read, line assembly, flush.
//
// BIU request handshake: biu_stb_o is raised in REQ and held, together with
// biu_adr_o/biu_len_o, until a cycle with biu_stb_ack_i high; beats are then
// accepted on every cycle with biu_ack_i high while in RECV. biu_err_i in REQ
// or RECV aborts the fill and overrides any simultaneous ack.
module riscv_cache_fill_ctrl
    import riscv_cache_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int PLEN       = XLEN,
    parameter int SIZE       = 4,
    parameter int BLOCK_SIZE = XLEN,
    parameter int WAYS       = 2
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  logic                                miss_i,
    input  logic [PLEN-1:0]                     miss_adr_i,
    input  logic                                flush_i,
    output logic                                busy_o,
    output logic                                filling_o,
    output logic                                flushing_o,
    output logic [WAYS-1:0]                     fill_way_select_o,
    output logic [get_blk_bits(BLOCK_SIZE)-1:0] line_o,
    output logic                                line_we_o,
    output logic                                biu_stb_o,
    input  logic                                biu_stb_ack_i,
    output logic [PLEN-1:0]                     biu_adr_o,
    output logic [7:0]                          biu_len_o,
    input  logic [XLEN-1:0]                     biu_d_i,
    input  logic                                biu_ack_i,
    input  logic                                biu_err_i,
    output logic                                err_o
);
    localparam int SETS          = get_sets(SIZE, BLOCK_SIZE, WAYS);
    localparam int IDX_BITS      = get_idx_bits(SIZE, BLOCK_SIZE, WAYS);
    localparam int BLK_OFFS_BITS = get_blk_offs_bits(BLOCK_SIZE);
    localparam int BLK_BITS      = get_blk_bits(BLOCK_SIZE);
    localparam int BEATS         = BLK_BITS / XLEN;
    localparam int CNT_BITS      = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_BITS-1:0] LAST_BEAT = CNT_BITS'(BEATS - 1);
    localparam logic [PLEN-1:0] LINE_MASK =
        {{(PLEN - BLK_OFFS_BITS){1'b1}}, {BLK_OFFS_BITS{1'b0}}};

    fill_state_e          state, next_state;
    logic [CNT_BITS-1:0]  cnt;
    logic [PLEN-1:0]      adr_q;
    logic [7:0]           len_q;
    logic [WAYS-1:0]      way_q;
    logic [BLK_BITS-1:0]  line_q;
    logic                 err_q;
    logic [WAYS-1:0]      victim_onehot;

    riscv_cache_victim_sel #(
        .SETS (SETS),
        .WAYS (WAYS),
        .IDX_W(IDX_BITS)
    ) u_victim_sel (
        .clk       (clk_i),
        .rst_n     (rst_ni),
        .rd_idx    (miss_adr_i[BLK_OFFS_BITS +: IDX_BITS]),
        .way_onehot(victim_onehot),
        .inc       (state == ST_WRITE),
        .inc_idx   (adr_q[BLK_OFFS_BITS +: IDX_BITS]),
        .clear     (state == ST_FLUSH)
    );

    // State register and fill datapath (address, way, beat counter, line).
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            adr_q  <= '0;
            len_q  <= '0;
            way_q  <= '0;
            line_q <= '0;
            err_q  <= 1'b0;
        end else begin
            state <= next_state;
            err_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (!flush_i && miss_i) begin
                        adr_q <= miss_adr_i & LINE_MASK;
                        len_q <= 8'(BEATS - 1);
                        way_q <= victim_onehot;
                    end
                end
                ST_REQ: begin
                    if (biu_err_i) begin
                        err_q <= 1'b1;
                    end else if (biu_stb_ack_i) begin
                        cnt <= '0;
                    end
                end
                ST_RECV: begin
                    if (biu_err_i) begin
                        err_q <= 1'b1;
                    end else if (biu_ack_i) begin
                        line_q[int'(cnt) * XLEN +: XLEN] <= biu_d_i;
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Next-state decode and state-derived strobes.
    always_comb begin
        next_state = state;
        busy_o     = 1'b1;
        filling_o  = 1'b0;
        flushing_o = 1'b0;
        line_we_o  = 1'b0;
        biu_stb_o  = 1'b0;
        case (state)
            ST_IDLE: begin
                busy_o = 1'b0;
                if (flush_i) begin
                    next_state = ST_FLUSH;
                end else if (miss_i) begin
                    next_state = ST_REQ;
                end
            end
            ST_REQ: begin
                filling_o = 1'b1;
                biu_stb_o = 1'b1;
                if (biu_err_i) begin
                    next_state = ST_IDLE;
                end else if (biu_stb_ack_i) begin
                    next_state = ST_RECV;
                end
            end
            ST_RECV: begin
                filling_o = 1'b1;
                if (biu_err_i) begin
                    next_state = ST_IDLE;
                end else if (biu_ack_i && cnt == LAST_BEAT) begin
                    next_state = ST_WRITE;
                end
            end
            ST_WRITE: begin
                filling_o  = 1'b1;
                line_we_o  = 1'b1;
                next_state = ST_IDLE;
            end
            ST_FLUSH: begin
                flushing_o = 1'b1;
                next_state = ST_IDLE;
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    assign fill_way_select_o = way_q;
    assign line_o            = line_q;
    assign biu_adr_o         = adr_q;
    assign biu_len_o         = len_q;
    assign err_o             = err_q;

endmodule

// File: tb/tb_riscv_cache_fill_ctrl.sv
// Directed bench for riscv_cache_fill_ctrl with a transaction-level model.
module tb_riscv_cache_fill_ctrl;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         miss;
    logic [31:0]  miss_adr;
    logic         flush;
    logic         busy, filling, flushing, line_we, biu_stb, err;
    logic [1:0]   way_sel;
    logic [255:0] line;
    logic         biu_stb_ack;
    logic [31:0]  biu_adr;
    logic [7:0]   biu_len;
    logic [31:0]  biu_d;
    logic         biu_ack;
    logic         biu_err;

    int n_vec = 0;
    int n_bad = 0;

    // Model: line geometry 32 bytes, 64 sets, 2 ways, 8 beats.
    int           vptr [64];
    logic [31:0]  m_adr;
    logic [7:0]   m_len;
    logic [1:0]   m_way;
    logic [255:0] m_line;
    int           phase;     // 0 idle, 1 req, 2 recv, 3 write, 4 flush, 5 idle+err
    logic         check_en = 1'b0;

    riscv_cache_fill_ctrl dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .miss_i           (miss),
        .miss_adr_i       (miss_adr),
        .flush_i          (flush),
        .busy_o           (busy),
        .filling_o        (filling),
        .flushing_o       (flushing),
        .fill_way_select_o(way_sel),
        .line_o           (line),
        .line_we_o        (line_we),
        .biu_stb_o        (biu_stb),
        .biu_stb_ack_i    (biu_stb_ack),
        .biu_adr_o        (biu_adr),
        .biu_len_o        (biu_len),
        .biu_d_i          (biu_d),
        .biu_ack_i        (biu_ack),
        .biu_err_i        (biu_err),
        .err_o            (err)
    );

    // Clock
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Compare every output against the model on the falling edge.
    always @(negedge clk) begin
        if (check_en) begin
            chk("busy",     256'(busy),     256'(phase >= 1 && phase <= 4));
            chk("filling",  256'(filling),  256'(phase >= 1 && phase <= 3));
            chk("flushing", 256'(flushing), 256'(phase == 4));
            chk("line_we",  256'(line_we),  256'(phase == 3));
            chk("biu_stb",  256'(biu_stb),  256'(phase == 1));
            chk("err",      256'(err),      256'(phase == 5));
            chk("biu_adr",  256'(biu_adr),  256'(m_adr));
            chk("biu_len",  256'(biu_len),  256'(m_len));
            chk("way_sel",  256'(way_sel),  256'(m_way));
            chk("line",     line,           m_line);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        for (int s = 0; s < 64; s++) vptr[s] = 0;
        m_adr  = '0;
        m_len  = '0;
        m_way  = '0;
        m_line = '0;
    endtask

    // One miss from an idle cycle. err_beat / rst_beat / gap_beat = -1 disables.
    task automatic fill(input logic [31:0] addr, input int ack_delay, input int err_beat,
                        input int rst_beat, input int gap_beat, input bit seq_data);
        int idx;
        logic [31:0] data;
        idx = int'((addr >> 5) & 32'd63);
        miss = 1'b1;
        miss_adr = addr;
        step();
        miss = 1'b0;
        miss_adr = $urandom;
        m_adr = addr & 32'hFFFF_FFE0;
        m_len = 8'd7;
        m_way = 2'(1 << vptr[idx]);
        phase = 1;
        // Beats offered before the request is accepted must be ignored.
        for (int k = 0; k < ack_delay; k++) begin
            biu_ack = 1'b1;
            biu_d = $urandom;
            miss_adr = $urandom;
            step();
            phase = 1;
        end
        biu_ack = 1'b0;
        biu_stb_ack = 1'b1;
        step();
        biu_stb_ack = 1'b0;
        phase = 2;
        for (int i = 0; i < 8; i++) begin
            if (i == gap_beat) begin
                step();
                phase = 2;
            end
            data = seq_data ? 32'(i) : $urandom;
            biu_ack = 1'b1;
            biu_d = data;
            biu_err = (i == err_beat);
            rst_n = (i != rst_beat);
            step();
            biu_ack = 1'b0;
            biu_err = 1'b0;
            if (i == rst_beat) begin
                rst_n = 1'b1;
                model_clear();
                phase = 0;
                return;
            end
            if (i == err_beat) begin
                phase = 5;
                step();
                phase = 0;
                return;
            end
            m_line[i*32 +: 32] = data;
            if (i == 7) begin
                phase = 3;
                vptr[idx] = (vptr[idx] + 1) % 2;
                step();
                phase = 0;
            end else begin
                phase = 2;
            end
        end
    endtask

    task automatic do_flush(input bit with_miss, input logic [31:0] addr);
        flush = 1'b1;
        miss = with_miss;
        miss_adr = addr;
        step();
        flush = 1'b0;
        miss = 1'b0;
        for (int s = 0; s < 64; s++) vptr[s] = 0;
        phase = 4;
        step();
        phase = 0;
    endtask

    initial begin
        rst_n = 1'b0;
        miss = 1'b0;
        miss_adr = '0;
        flush = 1'b0;
        biu_stb_ack = 1'b0;
        biu_d = '0;
        biu_ack = 1'b0;
        biu_err = 1'b0;
        model_clear();
        phase = 0;
        step();
        check_en = 1'b1;
        step();
        rst_n = 1'b1;
        step();
        step();

        // Basic fill with sequential beats and a pause inside the burst.
        fill(32'h0000_1234, 0, -1, -1, 2, 1'b1);
        chk("lit_adr",  256'(biu_adr), 256'h1220);
        chk("lit_len",  256'(biu_len), 256'd7);
        chk("lit_way1", 256'(way_sel), 256'b01);
        chk("lit_line", line,
            256'h00000007_00000006_00000005_00000004_00000003_00000002_00000001_00000000);

        // Same set twice more: round-robin and wrap.
        fill(32'h0000_3230, 0, -1, -1, -1, 1'b0);
        chk("lit_way2", 256'(way_sel), 256'b10);
        fill(32'h0000_0220, 1, -1, -1, -1, 1'b0);
        chk("lit_way3", 256'(way_sel), 256'b01);
        fill(32'h0000_0040, 0, -1, -1, -1, 1'b0);

        // Flush beats a simultaneous miss; pointers cleared.
        do_flush(1'b1, 32'h0000_1234);
        step();
        fill(32'h0000_1234, 0, -1, -1, -1, 1'b0);
        chk("lit_way_flush", 256'(way_sel), 256'b01);

        // Error on beat 3: no write, pointer kept.
        fill(32'h0000_1234, 2, 3, -1, -1, 1'b0);
        fill(32'h0000_1234, 0, -1, -1, -1, 1'b0);
        chk("lit_way_err", 256'(way_sel), 256'b10);

        // Reset during beat 5, then clean restart.
        fill(32'h0000_1234, 0, -1, 5, -1, 1'b0);
        chk("lit_rst_line", line, 256'h0);
        fill(32'h0000_1234, 0, -1, -1, 4, 1'b1);
        chk("lit_way_rst", 256'(way_sel), 256'b01);

        // Request acceptance withheld for 10 cycles.
        fill(32'h0000_5678, 10, -1, -1, -1, 1'b0);
        chk("lit_adr2", 256'(biu_adr), 256'h5660);

        do_flush(1'b0, 32'h0);
        step();
        step();
        check_en = 1'b0;
        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
